// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared digit limit and anode polarity helper for the scan controller
package sevenseg_pkg;
  localparam int MAX_DIGITS = 16;
  function automatic logic [MAX_DIGITS-1:0] anode_vec(input logic [MAX_DIGITS-1:0] onehot, input logic en, input logic active_low);
    return active_low ? ~(en ? onehot : '0) : (en ? onehot : '0);
  endfunction
endpackage

// File: rtl/sevenseg_scan_ctrl_if.sv
// sevenseg_scan_ctrl_if: frame data/load inputs and scan outputs; master drives frames, slave is the controller
interface sevenseg_scan_ctrl_if #(parameter int NUM_DIGITS = 8);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0] digit_en_i;
  logic load_i;
  logic [3:0] nibble_o;
  logic [NUM_DIGITS-1:0] anode_o;
  logic [IW-1:0] digit_idx_o;
  logic pending_o;
  logic frame_o;
  modport master(output value_i, digit_en_i, load_i, input nibble_o, anode_o, digit_idx_o, pending_o, frame_o);
  modport slave(input value_i, digit_en_i, load_i, output nibble_o, anode_o, digit_idx_o, pending_o, frame_o);
endinterface

// File: rtl/sevenseg_prescaler.sv
// sevenseg_prescaler: slot counter (clk_i, rst_i in; tc = last slot cycle now, tc_nxt/blank_nxt = flags for next cycle)
module sevenseg_prescaler #(
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tc,
  output logic tc_nxt,
  output logic blank_nxt
);
  localparam int CW = $clog2(CLK_DIV);
  logic [CW-1:0] cnt, cnt_nxt;
  always_comb begin
    tc = cnt == CW'(CLK_DIV - 1);
    cnt_nxt = tc ? '0 : cnt + CW'(1);
    tc_nxt = cnt_nxt == CW'(CLK_DIV - 1);
    blank_nxt = cnt_nxt < CW'(BLANK_CYCLES);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= cnt_nxt;
endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: double-buffered seven-segment digit scanner (clk_i, rst_i, bus: frame in, nibble/anode/idx/pending/frame out)
module sevenseg_scan_ctrl import sevenseg_pkg::*; #(
  parameter int NUM_DIGITS = 8,
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input logic clk_i,
  input logic rst_i,
  sevenseg_scan_ctrl_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [IW-1:0] idx, idx_nxt;
  logic [4*NUM_DIGITS-1:0] act_val, act_val_nxt, shd_val;
  logic [NUM_DIGITS-1:0] act_en, act_en_nxt, shd_en;
  logic pending, tc, tc_nxt, blank_nxt, last, bnd;
  sevenseg_prescaler #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK_CYCLES)) u_pre (
    .clk_i(clk_i), .rst_i(rst_i), .tc(tc), .tc_nxt(tc_nxt), .blank_nxt(blank_nxt)
  );
  always_comb begin
    last = idx == IW'(NUM_DIGITS - 1);
    bnd = tc && last;
    idx_nxt = tc ? (last ? '0 : idx + IW'(1)) : idx;
    act_val_nxt = bnd && pending ? shd_val : act_val;
    act_en_nxt = bnd && pending ? shd_en : act_en;
  end
  assign bus.pending_o = pending;
  // Outputs are registered from next-state values so they move on the same edge as cnt/idx.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      idx <= '0;
      act_val <= '0;
      act_en <= '0;
      shd_val <= '0;
      shd_en <= '0;
      pending <= 1'b0;
      bus.nibble_o <= '0;
      bus.anode_o <= ANODE_ACTIVE_LOW != 0 ? '1 : '0;
      bus.digit_idx_o <= '0;
      bus.frame_o <= 1'b0;
    end else begin
      idx <= idx_nxt;
      act_val <= act_val_nxt;
      act_en <= act_en_nxt;
      if (bus.load_i) begin
        shd_val <= bus.value_i;
        shd_en <= bus.digit_en_i;
      end
      // A load in the boundary cycle keeps pending set for the freshly captured data.
      pending <= bus.load_i || (pending && !bnd);
      bus.nibble_o <= act_val_nxt[{idx_nxt, 2'b00} +: 4];
      bus.anode_o <= NUM_DIGITS'(anode_vec(MAX_DIGITS'(1) << idx_nxt, !blank_nxt && act_en_nxt[idx_nxt], ANODE_ACTIVE_LOW != 0));
      bus.digit_idx_o <= idx_nxt;
      bus.frame_o <= tc_nxt && idx_nxt == IW'(NUM_DIGITS - 1);
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed vector bench for sevenseg_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles)
module tb_sevenseg_scan_ctrl;
  typedef struct {
    int cyc;
    logic ld;
    logic [15:0] val;
    logic [3:0] en;
    logic [3:0] an;
    logic [3:0] nib;
    logic [1:0] idx;
    logic pend;
    logic frm;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  vec_t vt[$];
  logic [3:0] nib_exp[4];
  sevenseg_scan_ctrl_if #(.NUM_DIGITS(4)) bus();
  sevenseg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic check(input string tag, input logic [3:0] an, input logic [3:0] nib, input logic [1:0] idx, input logic pend, input logic frm);
    cmp({tag, " anode"}, 16'(bus.anode_o), 16'(an));
    cmp({tag, " nibble"}, 16'(bus.nibble_o), 16'(nib));
    cmp({tag, " idx"}, 16'(bus.digit_idx_o), 16'(idx));
    cmp({tag, " pending"}, 16'(bus.pending_o), 16'(pend));
    cmp({tag, " frame"}, 16'(bus.frame_o), 16'(frm));
  endtask
  initial begin
    // blank scan after reset, frame pulse every 32 cycles
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd0, 0, 0});
    vt.push_back('{30, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd3, 0, 1});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd0, 0, 0});
    vt.push_back('{31, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd3, 0, 1});
    // mid-frame load of 4321, applied at the boundary
    vt.push_back('{5, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd0, 0, 0});
    vt.push_back('{1, 1, 16'h4321, 4'hF, 4'hF, 4'h0, 2'd0, 1, 0});
    vt.push_back('{26, 0, 16'h0, 4'h0, 4'hF, 4'h0, 2'd3, 1, 1});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h1, 2'd0, 0, 0});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h1, 2'd0, 0, 0});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hE, 4'h1, 2'd0, 0, 0});
    vt.push_back('{5, 0, 16'h0, 4'h0, 4'hE, 4'h1, 2'd0, 0, 0});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h2, 2'd1, 0, 0});
    vt.push_back('{2, 0, 16'h0, 4'h0, 4'hD, 4'h2, 2'd1, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hB, 4'h3, 2'd2, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'h7, 4'h4, 2'd3, 0, 0});
    vt.push_back('{5, 0, 16'h0, 4'h0, 4'h7, 4'h4, 2'd3, 0, 1});
    // two loads in one frame, only the second is shown
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h1, 2'd0, 0, 0});
    vt.push_back('{3, 1, 16'hAAAA, 4'hF, 4'hE, 4'h1, 2'd0, 1, 0});
    vt.push_back('{10, 1, 16'hBEEF, 4'hF, 4'hD, 4'h2, 2'd1, 1, 0});
    vt.push_back('{18, 0, 16'h0, 4'h0, 4'h7, 4'h4, 2'd3, 1, 1});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'hF, 2'd0, 0, 0});
    vt.push_back('{2, 0, 16'h0, 4'h0, 4'hE, 4'hF, 2'd0, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hD, 4'hE, 2'd1, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hB, 4'hE, 2'd2, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'h7, 4'hB, 2'd3, 0, 0});
    vt.push_back('{5, 0, 16'h0, 4'h0, 4'h7, 4'hB, 2'd3, 0, 1});
    // pending 1111, then a load in the frame cycle itself with digits 1,3 disabled
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'hF, 2'd0, 0, 0});
    vt.push_back('{1, 1, 16'h1111, 4'hF, 4'hF, 4'hF, 2'd0, 1, 0});
    vt.push_back('{30, 0, 16'h0, 4'h0, 4'h7, 4'hB, 2'd3, 1, 1});
    vt.push_back('{1, 1, 16'h5678, 4'h5, 4'hF, 4'h1, 2'd0, 1, 0});
    vt.push_back('{2, 0, 16'h0, 4'h0, 4'hE, 4'h1, 2'd0, 1, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hD, 4'h1, 2'd1, 1, 0});
    vt.push_back('{21, 0, 16'h0, 4'h0, 4'h7, 4'h1, 2'd3, 1, 1});
    vt.push_back('{1, 0, 16'h0, 4'h0, 4'hF, 4'h8, 2'd0, 0, 0});
    vt.push_back('{2, 0, 16'h0, 4'h0, 4'hE, 4'h8, 2'd0, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hF, 4'h7, 2'd1, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hB, 4'h6, 2'd2, 0, 0});
    vt.push_back('{8, 0, 16'h0, 4'h0, 4'hF, 4'h5, 2'd3, 0, 0});
    vt.push_back('{5, 0, 16'h0, 4'h0, 4'hF, 4'h5, 2'd3, 0, 1});
    nib_exp = '{4'h8, 4'h7, 4'h6, 4'h5};
    bus.load_i = 1'b0;
    bus.value_i = '0;
    bus.digit_en_i = '0;
    step(3);
    check("reset", 4'hF, 4'h0, 2'd0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].ld) begin
        bus.value_i = vt[i].val;
        bus.digit_en_i = vt[i].en;
        bus.load_i = 1'b1;
        step(1);
        bus.load_i = 1'b0;
        step(vt[i].cyc - 1);
      end else step(vt[i].cyc);
      check($sformatf("v%0d", i), vt[i].an, vt[i].nib, vt[i].idx, vt[i].pend, vt[i].frm);
    end
    // a full frame with en=0101: digits 1 and 3 stay dark, nibbles still cycle
    for (int i = 0; i < 32; i++) begin
      step(1);
      cmp($sformatf("mask%0d an13", i), 16'({bus.anode_o[3], bus.anode_o[1]}), 16'h3);
      cmp($sformatf("mask%0d nibble", i), 16'(bus.nibble_o), 16'(nib_exp[i / 8]));
    end
    // async reset mid-slot while a load is pending
    step(5);
    bus.value_i = 16'h9999;
    bus.digit_en_i = 4'hF;
    bus.load_i = 1'b1;
    step(1);
    bus.load_i = 1'b0;
    cmp("pre_rst pending", 16'(bus.pending_o), 16'h1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", 4'hF, 4'h0, 2'd0, 0, 0);
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cmp($sformatf("post_rst%0d anode", i), 16'(bus.anode_o), 16'hF);
      cmp($sformatf("post_rst%0d nibble", i), 16'(bus.nibble_o), 16'h0);
      cmp($sformatf("post_rst%0d pending", i), 16'(bus.pending_o), 16'h0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
